// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: exception codes, default PCs and skid-buffer state encoding.
package pipe_pkg;

    localparam int unsigned EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = ST_EMPTY,
        StOne   = ST_ONE,
        StTwo   = ST_TWO
    } state_e;

endpackage

// File: rtl/exc_prio_merge.sv
// Combinational merge of N exception-code sources; the lowest-index nonzero source wins.
module exc_prio_merge #(
    parameter int unsigned EXC_N = 2,
    parameter int unsigned EXC_W = 5
) (
    input  logic [EXC_N*EXC_W-1:0] exc_i,
    output logic [EXC_W-1:0]       exc_o
);

    // Scan from the highest index down so the lowest nonzero source is written last.
    always_comb begin
        exc_o = '0;
        for (int i = int'(EXC_N) - 1; i >= 0; i--) begin
            if (exc_i[i*EXC_W +: EXC_W] != '0) begin
                exc_o = exc_i[i*EXC_W +: EXC_W];
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, flush, interrupt bubble injection
// and exception-code merge on entry. All outputs come straight from flops.
module pipe_stage_skid #(
    parameter int unsigned PAYLOAD_W  = 96,
    parameter int unsigned EXC_N      = 2,
    parameter int unsigned EXC_W      = pipe_pkg::EXC_W,
    parameter logic [31:0] RESET_PC   = pipe_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] HANDLER_PC = pipe_pkg::DEFAULT_HANDLER_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   int_req,
    input  logic                   flush,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [31:0]            up_pc,
    input  logic [PAYLOAD_W-1:0]   up_payload,
    input  logic [EXC_N*EXC_W-1:0] up_exc,
    input  logic                   up_bd,
    input  logic                   up_branch,
    output logic                   dn_valid,
    input  logic                   dn_ready,
    output logic [31:0]            dn_pc,
    output logic [PAYLOAD_W-1:0]   dn_payload,
    output logic [EXC_W-1:0]       dn_exc,
    output logic                   dn_bd,
    output logic                   dn_branch,
    output logic [1:0]             count
);
    import pipe_pkg::*;

    state_e                 state_q, state_d;
    logic                   up_ready_q, up_ready_d;
    logic [31:0]            pc_q, pc_d, skid_pc_q, skid_pc_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d, skid_payload_q, skid_payload_d;
    logic [EXC_W-1:0]       exc_q, exc_d, skid_exc_q, skid_exc_d;
    logic                   bd_q, bd_d, skid_bd_q, skid_bd_d;
    logic                   branch_q, branch_d, skid_branch_q, skid_branch_d;
    logic [EXC_W-1:0]       up_exc_merged;
    logic                   up_fire, dn_fire;

    exc_prio_merge #(
        .EXC_N (EXC_N),
        .EXC_W (EXC_W)
    ) u_exc_merge (
        .exc_i (up_exc),
        .exc_o (up_exc_merged)
    );

    assign up_fire = up_valid & up_ready_q;
    assign dn_fire = (state_q != StEmpty) & dn_ready;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        payload_d      = payload_q;
        exc_d          = exc_q;
        bd_d           = bd_q;
        branch_d       = branch_q;
        skid_pc_d      = skid_pc_q;
        skid_payload_d = skid_payload_q;
        skid_exc_d     = skid_exc_q;
        skid_bd_d      = skid_bd_q;
        skid_branch_d  = skid_branch_q;

        case (state_q)
            StEmpty: begin
                if (up_fire) begin
                    {pc_d, payload_d, exc_d, bd_d, branch_d} =
                        {up_pc, up_payload, up_exc_merged, up_bd, up_branch};
                    state_d = StOne;
                end
            end
            StOne: begin
                if (up_fire && dn_fire) begin
                    {pc_d, payload_d, exc_d, bd_d, branch_d} =
                        {up_pc, up_payload, up_exc_merged, up_bd, up_branch};
                end else if (up_fire) begin
                    {skid_pc_d, skid_payload_d, skid_exc_d, skid_bd_d, skid_branch_d} =
                        {up_pc, up_payload, up_exc_merged, up_bd, up_branch};
                    state_d = StTwo;
                end else if (dn_fire) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (dn_fire) begin
                    {pc_d, payload_d, exc_d, bd_d, branch_d} =
                        {skid_pc_q, skid_payload_q, skid_exc_q, skid_bd_q, skid_branch_q};
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Redirects override the handshake; the skid entry is simply abandoned.
        if (int_req) begin
            state_d   = StOne;
            pc_d      = HANDLER_PC;
            payload_d = '0;
            exc_d     = '0;
            bd_d      = 1'b0;
            branch_d  = 1'b0;
        end else if (flush) begin
            // Keep the offered PC and delay-slot flag visible so the EPC is still correct.
            state_d   = StEmpty;
            pc_d      = up_pc;
            payload_d = '0;
            exc_d     = '0;
            bd_d      = up_bd;
            branch_d  = 1'b0;
        end

        up_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StEmpty;
            up_ready_q     <= 1'b1;
            pc_q           <= RESET_PC;
            payload_q      <= '0;
            exc_q          <= '0;
            bd_q           <= 1'b0;
            branch_q       <= 1'b0;
            skid_pc_q      <= '0;
            skid_payload_q <= '0;
            skid_exc_q     <= '0;
            skid_bd_q      <= 1'b0;
            skid_branch_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            up_ready_q     <= up_ready_d;
            pc_q           <= pc_d;
            payload_q      <= payload_d;
            exc_q          <= exc_d;
            bd_q           <= bd_d;
            branch_q       <= branch_d;
            skid_pc_q      <= skid_pc_d;
            skid_payload_q <= skid_payload_d;
            skid_exc_q     <= skid_exc_d;
            skid_bd_q      <= skid_bd_d;
            skid_branch_q  <= skid_branch_d;
        end
    end

    assign up_ready   = up_ready_q;
    assign dn_valid   = (state_q != StEmpty);
    assign count      = state_q;
    assign dn_pc      = pc_q;
    assign dn_payload = payload_q;
    assign dn_exc     = exc_q;
    assign dn_bd      = bd_q;
    assign dn_branch  = branch_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table followed by random traffic against a
// queue-based reference model.
module tb_pipe_stage_skid;

    localparam int unsigned PAYLOAD_W = 96;
    localparam int unsigned EXC_N     = 2;
    localparam int unsigned EXC_W     = 5;
    localparam logic [31:0] HPC       = 32'h0000_4180;
    localparam logic [31:0] RPC       = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   reset, int_req, flush, up_valid, up_ready, up_bd, up_branch;
    logic [31:0]            up_pc, dn_pc;
    logic [PAYLOAD_W-1:0]   up_payload, dn_payload;
    logic [EXC_N*EXC_W-1:0] up_exc;
    logic                   dn_valid, dn_ready, dn_bd, dn_branch;
    logic [EXC_W-1:0]       dn_exc;
    logic [1:0]             count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PAYLOAD_W  (PAYLOAD_W),
        .EXC_N      (EXC_N),
        .EXC_W      (EXC_W),
        .RESET_PC   (RPC),
        .HANDLER_PC (HPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .int_req    (int_req),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_pc      (up_pc),
        .up_payload (up_payload),
        .up_exc     (up_exc),
        .up_bd      (up_bd),
        .up_branch  (up_branch),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_pc      (dn_pc),
        .dn_payload (dn_payload),
        .dn_exc     (dn_exc),
        .dn_bd      (dn_bd),
        .dn_branch  (dn_branch),
        .count      (count)
    );

    typedef struct {
        logic        rst, irq, fl, uv, dr;
        logic [31:0] pc, pl;
        logic [9:0]  exc;
        logic        bd, chk_data;
        logic        e_valid, e_ready;
        logic [1:0]  e_count;
        logic [31:0] e_pc, e_pl;
        logic [4:0]  e_exc;
        logic        e_bd;
    } vec_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [PAYLOAD_W-1:0] pl;
        logic [4:0]           exc;
        logic                 bd;
        logic                 br;
    } ent_t;

    vec_t vecs[20];
    ent_t mq[$];
    ent_t shown;
    logic shown_known;

    function automatic vec_t mk(input logic rst, irq, fl, uv, dr, input logic [31:0] pc, pl,
                                input logic [9:0] exc, input logic bd, chk,
                                input logic ev, er, input logic [1:0] ec,
                                input logic [31:0] epc, epl, input logic [4:0] eexc,
                                input logic ebd);
        vec_t v;
        v.rst = rst; v.irq = irq; v.fl = fl; v.uv = uv; v.dr = dr;
        v.pc = pc; v.pl = pl; v.exc = exc; v.bd = bd; v.chk_data = chk;
        v.e_valid = ev; v.e_ready = er; v.e_count = ec;
        v.e_pc = epc; v.e_pl = epl; v.e_exc = eexc; v.e_bd = ebd;
        return v;
    endfunction

    // Lowest-numbered source with a nonzero code wins.
    function automatic logic [4:0] merge(input logic [9:0] v);
        for (int i = 0; i < int'(EXC_N); i++) begin
            if (v[i*5 +: 5] != 5'd0) return v[i*5 +: 5];
        end
        return 5'd0;
    endfunction

    task automatic check(input string what, input int idx, input logic [159:0] got,
                         input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", what, idx, got, exp);
        end
    endtask

    task automatic drive(input logic rst, irq, fl, uv, dr, input logic [31:0] pc,
                         input logic [PAYLOAD_W-1:0] pl, input logic [9:0] exc,
                         input logic bd, br);
        reset = rst; int_req = irq; flush = fl; up_valid = uv; dn_ready = dr;
        up_pc = pc; up_payload = pl; up_exc = exc; up_bd = bd; up_branch = br;
    endtask

    // One cycle of the reference model, using the inputs currently driven.
    task automatic model_step();
        bit   rdy, ufire, dfire;
        ent_t e, last;
        rdy = (mq.size() < 2);
        if (reset) begin
            mq.delete();
            shown = '{pc: RPC, default: '0};
            shown_known = 1'b1;
        end else if (int_req) begin
            mq.delete();
            mq.push_back('{pc: HPC, default: '0});
        end else if (flush) begin
            mq.delete();
            shown = '{pc: up_pc, bd: up_bd, default: '0};
            shown_known = 1'b1;
        end else begin
            dfire = (mq.size() > 0) && dn_ready;
            ufire = up_valid && rdy;
            if (dfire) begin
                last = mq.pop_front();
                if (mq.size() == 0) begin
                    shown = last;
                    shown_known = 1'b0;
                end
            end
            if (ufire) begin
                e.pc = up_pc; e.pl = up_payload; e.exc = merge(up_exc);
                e.bd = up_bd; e.br = up_branch;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_check(input int idx);
        ent_t exp_e, got_e;
        logic valid;
        valid = (mq.size() > 0);
        check("ctrl", idx, {157'd0, dn_valid, up_ready, count},
              {157'd0, valid, mq.size() < 2, 2'(mq.size())});
        if (valid || shown_known) begin
            exp_e = valid ? mq[0] : shown;
            got_e = '{pc: dn_pc, pl: dn_payload, exc: dn_exc, bd: dn_bd, br: dn_branch};
            check("data", idx, 160'(got_e), 160'(exp_e));
        end
    endtask

    initial begin
        //          rst irq fl uv dr pc            pl            exc     bd chk ev er ec  epc           epl           eexc  ebd
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,       32'h0,        10'h0,   0, 1, 0, 1, 0, 32'h0,       32'h0,        5'd0,  0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,       32'h0,        10'h0,   0, 1, 0, 1, 0, 32'h0,       32'h0,        5'd0,  0);
        vecs[2]  = mk(0, 0, 0, 1, 1, 32'h3000,    32'hA000_3000, 10'd12, 0, 1, 1, 1, 1, 32'h3000,    32'hA000_3000, 5'd12, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 32'h3004,    32'hA000_3004, 10'h0,  1, 1, 1, 0, 2, 32'h3000,    32'hA000_3000, 5'd12, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 32'h3008,    32'hA000_3008, 10'h0,  0, 1, 1, 0, 2, 32'h3000,    32'hA000_3000, 5'd12, 0);
        vecs[5]  = mk(0, 0, 0, 1, 1, 32'h3008,    32'hA000_3008, 10'h0,  0, 1, 1, 1, 1, 32'h3004,    32'hA000_3004, 5'd0,  1);
        vecs[6]  = mk(0, 0, 0, 1, 1, 32'h3008,    32'hA000_3008, 10'h0,  0, 1, 1, 1, 1, 32'h3008,    32'hA000_3008, 5'd0,  0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h0,       32'h0,        10'h0,   0, 0, 0, 1, 0, 32'h0,       32'h0,        5'd0,  0);
        vecs[8]  = mk(0, 0, 0, 1, 0, 32'h300C,    32'hA000_300C, 10'h0,  0, 1, 1, 1, 1, 32'h300C,    32'hA000_300C, 5'd0,  0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,       32'h0,        10'h0,   0, 1, 1, 1, 1, 32'h300C,    32'hA000_300C, 5'd0,  0);
        vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,       32'h0,        10'h0,   0, 1, 1, 1, 1, 32'h300C,    32'hA000_300C, 5'd0,  0);
        vecs[11] = mk(0, 0, 0, 1, 0, 32'h3010,    32'hA000_3010, 10'h0,  0, 1, 1, 0, 2, 32'h300C,    32'hA000_300C, 5'd0,  0);
        vecs[12] = mk(0, 1, 0, 1, 0, 32'h3014,    32'hA000_3014, 10'd12, 1, 1, 1, 1, 1, 32'h4180,    32'h0,        5'd0,  0);
        vecs[13] = mk(0, 0, 0, 0, 1, 32'h0,       32'h0,        10'h0,   0, 0, 0, 1, 0, 32'h0,       32'h0,        5'd0,  0);
        vecs[14] = mk(0, 0, 1, 0, 0, 32'h3010,    32'hA000_3010, 10'd12, 1, 1, 0, 1, 0, 32'h3010,    32'h0,        5'd0,  1);
        vecs[15] = mk(0, 0, 0, 1, 0, 32'h3020,    32'hA000_3020, 10'h140, 0, 1, 1, 1, 1, 32'h3020,   32'hA000_3020, 5'd10, 0);
        vecs[16] = mk(0, 0, 0, 1, 0, 32'h3024,    32'hA000_3024, 10'h085, 0, 1, 1, 0, 2, 32'h3020,   32'hA000_3020, 5'd10, 0);
        vecs[17] = mk(0, 0, 0, 0, 1, 32'h0,       32'h0,        10'h0,   0, 1, 1, 1, 1, 32'h3024,    32'hA000_3024, 5'd5,  0);
        vecs[18] = mk(0, 0, 1, 1, 0, 32'h3030,    32'hA000_3030, 10'd12, 0, 1, 0, 1, 0, 32'h3030,    32'h0,        5'd0,  0);
        vecs[19] = mk(1, 1, 1, 1, 1, 32'h3040,    32'hA000_3040, 10'd12, 1, 1, 0, 1, 0, 32'h0,       32'h0,        5'd0,  0);

        drive(1, 0, 0, 0, 0, '0, '0, '0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].irq, vecs[i].fl, vecs[i].uv, vecs[i].dr, vecs[i].pc,
                  {64'd0, vecs[i].pl}, vecs[i].exc, vecs[i].bd, 1'b0);
            @(negedge clk);
            check("vec_ctrl", i, {157'd0, dn_valid, up_ready, count},
                  {157'd0, vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_count});
            if (vecs[i].chk_data) begin
                check("vec_data", i, {22'd0, dn_pc, dn_payload, dn_exc, dn_bd},
                      {22'd0, vecs[i].e_pc, 64'd0, vecs[i].e_pl, vecs[i].e_exc, vecs[i].e_bd});
            end
        end

        // Random traffic against the queue model.
        drive(1, 0, 0, 0, 0, '0, '0, '0, 0, 0);
        model_step();
        @(negedge clk);
        model_check(-1);
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] ex;
            for (int s = 0; s < int'(EXC_N); s++) begin
                ex[s*5 +: 5] = ($urandom_range(1) == 1) ? 5'($urandom_range(31, 1)) : 5'd0;
            end
            drive($urandom_range(99) == 0, $urandom_range(49) == 0, $urandom_range(32) == 0,
                  $urandom_range(9) < 7, $urandom_range(9) < 6, $urandom,
                  {$urandom, $urandom, $urandom}, ex, 1'($urandom_range(1)),
                  1'($urandom_range(1)));
            model_step();
            @(negedge clk);
            model_check(c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a two-entry skid buffer, valid/ready handshake, flush, interrupt injection and N-source exception-code priority merge. It replaces the fixed E→M / M→W stage registers so that a stage can stall on a multi-cycle bus without combinational ready paths. It also carries PC, branch-delay and branch flags alongside an opaque payload.

## Interface
Parameters:
- PAYLOAD_W, 96: opaque payload width (instr, rt value, calc result).
- EXC_N, 2: number of exception-code sources merged on entry.
- EXC_W, 5: ExcCode width.
- RESET_PC, 32'h0000_0000: dn_pc value after reset.
- HANDLER_PC, 32'h0000_4180: dn_pc of the bubble injected on int_req.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- int_req  in  1  interrupt/exception redirect; empties the buffer and injects a handler bubble.
- flush  in  1  empties the buffer and leaves an invalid bubble.
- up_valid  in  1  upstream entry offered.
- up_ready  out  1  registered; stage can accept an entry.
- up_pc  in  32  entry PC.
- up_payload  in  PAYLOAD_W  entry payload.
- up_exc  in  EXC_N*EXC_W  slice i = source i ExcCode; 0 = none.
- up_bd  in  1  entry is in a delay slot.
- up_branch  in  1  entry is a branch/jump.
- dn_valid  out  1  head entry valid.
- dn_ready  in  1  downstream accepts the head.
- dn_pc  out  32  head PC.
- dn_payload  out  PAYLOAD_W  head payload.
- dn_exc  out  EXC_W  head merged ExcCode.
- dn_bd  out  1  head delay-slot flag.
- dn_branch  out  1  head branch flag.
- count  out  2  occupancy: 0, 1 or 2.

## Operation
- Handshake events:
  - up_fire = up_valid & up_ready.
  - dn_fire = dn_valid & dn_ready.
- Exception merge is applied on entry. The lowest index i with a nonzero slice wins; index 0 is this stage's own detection. If all slices are zero, the result is 0. The merged code is stored, never the raw vector.
- Storage:
  - main entry drives all dn_* outputs.
  - skid entry holds the overflow entry. Order is FIFO.
- States are EMPTY, ONE and TWO. count = 0, 1, 2 respectively.
  - EMPTY, up_fire → ONE: main loads the up entry.
  - ONE, up_fire & dn_fire → ONE: main loads the up entry.
  - ONE, up_fire only → TWO: skid loads the up entry.
  - ONE, dn_fire only → EMPTY.
  - TWO, dn_fire → ONE: main loads skid. up_ready is 0 in TWO.
- dn_valid = (state != EMPTY).
- up_ready is registered: 1 in EMPTY and ONE, 0 in TWO. Its next value follows the next state.
- Priority order: reset > int_req > flush > normal operation.
- int_req, next cycle:
  - state ONE, dn_valid = 1.
  - dn_pc = HANDLER_PC.
  - payload, exc, bd and branch all 0.
  - skid discarded; any up_fire in the same cycle is discarded.
- flush, next cycle:
  - state EMPTY, dn_valid = 0.
  - dn_pc = up_pc and dn_bd = up_bd, so CP0 sees a correct EPC.
  - payload, exc and branch are 0.
- Reset values:
  - dn_valid = 0, up_ready = 1, count = 0.
  - dn_pc = RESET_PC.
  - dn_payload, dn_exc, dn_bd, dn_branch = 0.
- With flush, int_req and dn_ready all low and state ONE, main holds its value indefinitely.

## Timing
- Latency: 1 cycle from up_fire into EMPTY to dn_valid.
- Throughput: 1 entry/cycle while dn_ready = 1.
- No combinational path between dn_ready and up_ready, or from any up_* input to any dn_* output.
- dn_ready may drop at any cycle. At most one extra entry is absorbed, into skid.
- Reset or int_req asserted mid-transfer: the pending entry is dropped; no partial update.
- A dn_fire in the same cycle as flush or int_req still counts as consumed downstream. The stage does not replay it.

## Structure
- Shared package pipe_pkg:
  - EXC_W.
  - ExcCode constants: EXC_NONE = 0, EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
  - HANDLER_PC and RESET_PC defaults.
  - state encoding localparams.
- Sub-module exc_prio_merge: purely combinational, parametrised EXC_N / EXC_W, reused by the W-stage instance.

## Test plan
- Reset then idle → dn_valid = 0, up_ready = 1, count = 0, dn_pc = 0.
- up_exc = {5'd0, 5'd12}, pc 0x3000 with dn_ready = 1 → next cycle dn_exc = 12, dn_pc = 0x3000, dn_valid = 1.
- Stream 0x3000, 0x3004, 0x3008 with dn_ready = 0 for 2 cycles:
  - count goes 1 → 2, up_ready = 0 while count = 2.
  - After dn_ready rises, outputs appear in order 0x3000, 0x3004, 0x3008 with none lost or duplicated.
- State TWO, int_req = 1 → next cycle count = 1, dn_pc = 0x4180, dn_payload = 0, dn_exc = 0, up_ready = 1.
- flush with up_pc = 0x3010, up_bd = 1 → next cycle dn_valid = 0, dn_pc = 0x3010, dn_bd = 1, count = 0.
- reset, int_req and flush all asserted in one cycle → reset values result (dn_pc = 0, count = 0).
